apb_mig_master: RTL and testbench
=================================

# apb_mig_master

Single-outstanding APB4 requester that drives the master side of the `apb_mig_if` bus toward the APB-to-MIG slave. It accepts one memory request at a time on a valid/ready command port and runs the APB setup and access phases. It waits out slave wait states, or aborts on a configurable timeout. It then returns read data and error status on a valid/ready response port. It is used by on-chip agents (test sequencers, boot loaders) that need DDR access through the APB bridge.

## Interface

Parameters:
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 32: APB data width; must be a multiple of 8.
- `TIMEOUT`, 256: maximum access-phase cycles before abort; 0 disables the timeout.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `pclk_i`, input, 1: clock.
- `preset_n`, input, 1: asynchronous active-low reset.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: request ready; high only in IDLE.
- `req_addr_i`, input, ADDR_W: request address.
- `req_write_i`, input, 1: 1 = write, 0 = read.
- `req_wdata_i`, input, DATA_W: write data.
- `req_strb_i`, input, DATA_W/8: write byte strobes.
- `rsp_valid_o`, output, 1: response valid.
- `rsp_ready_i`, input, 1: response accepted.
- `rsp_rdata_o`, output, DATA_W: read data; 0 for writes and timeouts.
- `rsp_slverr_o`, output, 1: `pslverr` was sampled high, or the access timed out.
- `rsp_timeout_o`, output, 1: the access was aborted by the timeout.
- `paddr_o`, output, ADDR_W: APB address.
- `pwdata_o`, output, DATA_W: APB write data.
- `pwrite_o`, output, 1: APB write.
- `psel_o`, output, 1: APB select.
- `penable_o`, output, 1: APB enable.
- `pstrb_o`, output, DATA_W/8: APB strobes.
- `prdata_i`, input, DATA_W: APB read data.
- `pready_i`, input, 1: APB ready.
- `pslverr_i`, input, 1: APB slave error.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i && req_ready_o`, register addr, write, wdata and strb, then go to SETUP.
- SETUP:
  - `psel_o`=1, `penable_o`=0 for exactly one cycle.
  - Clear the timeout counter.
  - Go to ACCESS.
- ACCESS:
  - `psel_o`=1, `penable_o`=1.
  - If `pready_i`=1: capture `rsp_rdata_o` (= `prdata_i` for reads, 0 for writes) and `rsp_slverr_o` (= `pslverr_i`), set `rsp_timeout_o`=0, go to RESP.
  - Else if `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1: set `rsp_slverr_o`=1, `rsp_timeout_o`=1, `rsp_rdata_o`=0, go to RESP.
  - Else increment the counter and stay in ACCESS.
  - `pready_i` takes priority over timeout in the same cycle.
- RESP:
  - `rsp_valid_o`=1; response fields stay stable until the handshake.
  - On `rsp_ready_i`=1, go to IDLE.
  - `psel_o`=0 in this state.
- Bus signal stability:
  - `paddr_o`, `pwrite_o`, `pwdata_o` and `pstrb_o` come straight from the request registers.
  - They are constant from SETUP through the end of ACCESS.
  - They hold their last value while idle.
- Strobe rule: `pstrb_o` is forced to 0 on reads, per APB4.
- Counter width: $clog2(TIMEOUT+1); the counter never wraps.

## Timing

- Reset values:
  - FSM = IDLE.
  - `req_ready_o`=1 once reset is released; all other outputs 0, including `psel_o`, `penable_o` and `rsp_valid_o`.
- Reset mid-transfer: `psel_o` and `penable_o` drop asynchronously with `preset_n`; the pending request and response are discarded.
- Latency with a zero-wait slave: request accepted at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → `rsp_valid_o` in cycle 3.
- Each slave wait state adds one cycle.
- Minimum issue interval: 4 cycles (request accept → SETUP → ACCESS → RESP with immediate `rsp_ready_i`).
- No request is accepted while in RESP.
- Timeout: ACCESS lasts exactly `TIMEOUT` cycles with `pready_i` low, then RESP follows.
- `psel_o` is never asserted in the cycle after ACCESS.
- `penable_o` is high only in ACCESS.

## Test plan

- Zero-wait write, addr 0x100, wdata 0xDEADBEEF, strb 0xF: one SETUP cycle then one ACCESS cycle with stable bus signals; `rsp_valid_o` rises 3 cycles after the request handshake with slverr=0 and rdata=0.
- Read addr 0x104, slave inserts 2 wait states and returns 0x12345678: `pstrb_o`=0; ACCESS lasts 3 cycles; `rsp_rdata_o`=0x12345678; `req_ready_o` stays 0 throughout.
- Slave error on a read with `pslverr_i`=1 and `pready_i`=1 → `rsp_slverr_o`=1, `rsp_timeout_o`=0.
- `TIMEOUT`=4, `pready_i` tied to 0: ACCESS lasts exactly 4 cycles; response has slverr=1, timeout=1, rdata=0; the next request proceeds normally.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles → response stable, `req_ready_o`=0, no `psel_o`; release → IDLE on the next cycle.
- Assert `preset_n`=0 during ACCESS → `psel_o` and `penable_o` drop immediately; after release, IDLE with `rsp_valid_o`=0.

Source files
------------

// File: rtl/apb_mig_master.sv
// rtl/apb_mig_master.sv - single-outstanding APB4 requester toward the APB-to-MIG slave
module apb_mig_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                pclk_i,
  input  logic                preset_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                req_write_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_slverr_o,
  output logic                rsp_timeout_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic                pwrite_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  localparam int STRB_W = DATA_W / 8;
  // A disabled timeout still gets a 1-bit counter so the declaration stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              slverr_q;
  logic              timeout_q;
  logic              req_fire;
  logic              timeout_hit;

  assign req_fire    = req_valid_i && req_ready_o;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk_i or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_next = SETUP;
      end
      SETUP: begin
        psel_o     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_n) begin
    if (!preset_n) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (req_fire) begin
        addr_q  <= req_addr_i;
        write_q <= req_write_i;
        wdata_q <= req_wdata_i;
        strb_q  <= req_strb_i;
      end
      if (state == SETUP) cnt_q <= '0;
      // A completing slave wins over an expiring timeout in the same cycle.
      if (state == ACCESS) begin
        if (pready_i) begin
          rdata_q   <= write_q ? '0 : prdata_i;
          slverr_q  <= pslverr_i;
          timeout_q <= 1'b0;
        end else if (timeout_hit) begin
          rdata_q   <= '0;
          slverr_q  <= 1'b1;
          timeout_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign paddr_o       = addr_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = write_q ? strb_q : '0;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_slverr_o  = slverr_q;
  assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_mig_master.sv
// tb/tb_apb_mig_master.sv - directed table-driven bench for apb_mig_master
module tb_apb_mig_master;

  logic        pclk_i = 1'b0;
  logic        preset_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_write_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_slverr_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        psel_o;
  logic        penable_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int checks = 0;
  int failures = 0;

  apb_mig_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk_i(pclk_i), .preset_n(preset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_slverr_o(rsp_slverr_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
    .psel_o(psel_o), .penable_o(penable_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prd;
    logic        perr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    @(negedge pclk_i);
    chk("idle_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i  = v.addr;
    req_write_i = v.wr;
    req_wdata_i = v.wdata;
    req_strb_i  = v.strb;
    prdata_i    = v.prd;
    @(posedge pclk_i);
    @(negedge pclk_i);
    req_valid_i = 1'b0;
    req_addr_i  = 32'hFFFF_FFFF;
    chk("setup_sel_en", {psel_o, penable_o, req_ready_o}, 3'b100);
    chk("setup_pstrb", pstrb_o, v.wr ? v.strb : 4'h0);
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk_i);
      if (!penable_o) break;
      chk("access_bus", {psel_o, req_ready_o, paddr_o, pwrite_o, pwdata_o, pstrb_o},
          {1'b1, 1'b0, v.addr, v.wr, v.wdata, v.wr ? v.strb : 4'h0});
      pready_i  = (acc == v.waits);
      pslverr_i = pready_i ? v.perr : 1'b0;
      acc++;
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    chk("access_cycles", acc, v.exp_acc);
    chk("resp_ctrl", {rsp_valid_o, psel_o, penable_o, req_ready_o}, 4'b1000);
    chk("resp_rdata", rsp_rdata_o, v.exp_rdata);
    chk("resp_err_to", {rsp_slverr_o, rsp_timeout_o}, {v.exp_err, v.exp_to});
    rsp_ready_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    rsp_ready_i = 1'b0;
    chk("back_idle", {rsp_valid_o, req_ready_o}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //           wr    addr          wdata         strb  waits prd           perr  exp_rdata     err   to    acc
    vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0,  32'h1111_1111, 1'b0, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_0104, 32'h0,         4'hF, 2,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 3};
    vecs[2] = '{1'b0, 32'h0000_0108, 32'h0,         4'h0, 0,  32'hAAAA_5555, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 32'h0000_010C, 32'h0,         4'hF, 99, 32'h5A5A_5A5A, 1'b0, 32'h0,        1'b1, 1'b1, 4};
    vecs[4] = '{1'b1, 32'h0000_0200, 32'hCAFE_0001, 4'h3, 3,  32'h7777_7777, 1'b1, 32'h0,        1'b1, 1'b0, 4};
    vecs[5] = '{1'b1, 32'h0000_0208, 32'h0102_0304, 4'h5, 1,  32'h0,         1'b0, 32'h0,        1'b0, 1'b0, 2};
    vecs[6] = '{1'b0, 32'h0000_0300, 32'h0,         4'hF, 0,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 1};

    preset_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0;
    req_wdata_i = '0; req_strb_i = '0; rsp_ready_i = 1'b0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    @(negedge pclk_i);
    chk("reset_outputs", {psel_o, penable_o, rsp_valid_o, rsp_rdata_o, rsp_slverr_o, rsp_timeout_o}, '0);
    preset_n = 1'b1;
    @(negedge pclk_i);
    chk("reset_ready", req_ready_o, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Backpressure: response held for 5 cycles while a new request waits.
    @(negedge pclk_i);
    req_valid_i = 1'b1; req_addr_i = 32'h400; req_write_i = 1'b0; req_strb_i = 4'hF;
    @(posedge pclk_i);
    @(negedge pclk_i);
    req_addr_i = 32'h999;
    @(negedge pclk_i);
    pready_i = 1'b1; prdata_i = 32'hCAFE_F00D;
    @(negedge pclk_i);
    pready_i = 1'b0; prdata_i = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid_o, req_ready_o, psel_o, rsp_rdata_o, paddr_o},
          {1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h400});
      @(negedge pclk_i);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge pclk_i);
    @(negedge pclk_i);
    rsp_ready_i = 1'b0;
    chk("bp_release", {rsp_valid_o, req_ready_o, psel_o}, 3'b010);

    // Reset asserted in the middle of ACCESS.
    req_valid_i = 1'b1; req_addr_i = 32'h500; req_write_i = 1'b1; req_wdata_i = 32'h55;
    @(posedge pclk_i);
    @(negedge pclk_i);
    req_valid_i = 1'b0;
    @(negedge pclk_i);
    chk("rst_pre_access", {psel_o, penable_o}, 2'b11);
    #1 preset_n = 1'b0;
    #1 chk("rst_async_drop", {psel_o, penable_o, rsp_valid_o}, 3'b000);
    @(negedge pclk_i);
    preset_n = 1'b1;
    @(negedge pclk_i);
    chk("rst_after", {req_ready_o, rsp_valid_o, psel_o}, 3'b100);

    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
